ln_prescaler: RTL and testbench
===============================

LN_PRESCALER -- requirements
Module: ln_prescaler

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the counter and preset width in bits.
REQ-002 The block SHALL have input cp0, 1 bit: the single clock, on which all state changes on the rising edge.
REQ-003 The block SHALL have input mr_n, 1 bit: master reset, asynchronous and active-low.
REQ-004 The block SHALL have input p, WIDTH bits: the divide ratio N.
REQ-005 The block SHALL have input pe, 1 bit: synchronous parallel enable, which forces an immediate load of p.
REQ-006 The block SHALL have input inh, 1 bit: clock inhibit; when high, the counter holds.
REQ-007 The block SHALL have output q, WIDTH bits: the current down-count value.
REQ-008 The block SHALL have output tc, 1 bit: terminal-count pulse, one cp0 cycle wide, used to drive a downstream decade counter clock.
REQ-009 The block SHALL have output div_out, 1 bit: toggles on every tc, giving a clock divided by 2N.

Function
REQ-010 The block SHALL hold an internal ratio register, ratio, of WIDTH bits, which is loaded from p only when pe is high or when the count wraps.
REQ-011 On each cp0 rise with mr_n high, inh low and pe low, the block SHALL decrement q by 1 when q > 1.
REQ-012 When q = 1 under the conditions of REQ-011, the block SHALL:
- load ratio from p;
- load q from p;
- assert tc for exactly that following cycle.
REQ-013 When ratio = 1, tc SHALL be high on every enabled cycle, so the output rate is cp0/1.
REQ-014 When p = 0 at a reload, q SHALL go to 0, tc SHALL stay low, and the counter SHALL stall until pe loads a non-zero p.
REQ-015 When pe is high, the block SHALL load q and ratio from p and hold tc low, regardless of inh.
REQ-016 pe SHALL take priority over count and inhibit.
REQ-017 When inh is high and pe is low, q, ratio and div_out SHALL hold, and tc SHALL be low.
REQ-018 tc SHALL be registered (glitch-free) and SHALL never be high for two consecutive cycles unless ratio = 1.
REQ-019 div_out SHALL toggle on the cp0 edge that ends each tc-high cycle.
REQ-020 Steady-state latency from a reload to the next tc SHALL be exactly ratio cycles.
REQ-021 A change of p while counting SHALL NOT affect the current period and SHALL take effect from the next reload.
REQ-022 All arithmetic SHALL be unsigned WIDTH-bit, and q SHALL never wrap below 0.

Reset
REQ-023 While mr_n is low, the block SHALL hold q = 0, ratio = 0, tc = 0 and div_out = 0, asynchronously and regardless of cp0.
REQ-024 On the first cp0 rise after mr_n deasserts, the block SHALL perform a reload from p as if q = 1, but without a tc pulse, so counting starts without manual pe.
REQ-025 A reset assertion mid-period SHALL abort the period immediately, with no tc emitted.

Structure
REQ-026 The default WIDTH and the ratio-0 "stalled" encoding SHALL live in the shared parts constants include, used by all divider/counter parts.
REQ-027 The block SHALL be a single module with no sub-module; the terminal detect (q = 1) SHALL stay inline.
REQ-028 tc and div_out SHALL be flop outputs, so they can feed the decade counter's cp0 directly.

Verification
REQ-029 Reset, then p = 3 held, 12 cycles -> the first edge reloads q to 3 without tc, q then runs 3,2,1,3,2,1..., tc is high one cycle in every 3, and div_out period is 6 cycles.
REQ-030 p = 1 -> tc is high continuously after the first reload, and div_out toggles every cycle.
REQ-031 p = 5, change p to 2 when q = 4 -> the current period completes as 5, then the period becomes 2.
REQ-032 p = 4, pe pulsed when q = 2 -> q = 4 on the next cycle, no tc, and tc comes 4 cycles later.
REQ-033 inh high for 3 cycles mid-count with q = 2 -> q holds at 2 and tc stays low, then counting resumes, extending the period by exactly 3 cycles.
REQ-034 p = 0 reload -> q = 0 and tc stays low indefinitely; mr_n low mid-count -> all outputs are 0 immediately, without waiting for cp0.

Source files
------------

// File: rtl/ln_prescaler_pkg.sv
// ----------------------------------------------------------------------------
// ln_prescaler_pkg
// Constants shared by the divider/counter parts:
//   LN_DEFAULT_WIDTH  - default counter/preset width in bits
//   LN_RATIO_STALLED  - ratio encoding meaning "loaded with 0, counter stalled"
// Also holds the per-edge action type used by ln_prescaler.
// ----------------------------------------------------------------------------
package ln_prescaler_pkg;

    localparam int unsigned LN_DEFAULT_WIDTH = 4;
    localparam int unsigned LN_RATIO_STALLED = 0;

    // What the prescaler does on the next cp0 rise.
    typedef enum logic [2:0] {
        ACT_LOAD,   // pe: parallel load of p
        ACT_HOLD,   // inh: freeze everything, tc low
        ACT_START,  // first edge after reset: reload without tc
        ACT_STALL,  // ratio 0: wait for pe
        ACT_WRAP,   // q = 1: reload from p and pulse tc
        ACT_DEC     // q > 1: count down
    } ln_act_e;

endpackage

// File: rtl/ln_prescaler.sv
// ----------------------------------------------------------------------------
// ln_prescaler
// Programmable divide-by-N down-counter. Counts p, p-1, ..., 1 and reloads,
// emitting a one-cycle registered terminal-count pulse per period and a
// toggle output running at cp0 / 2N.
//
// Ports:
//   cp0     in   clock, all state changes on the rising edge
//   mr_n    in   master reset, asynchronous, active-low
//   p       in   divide ratio N (WIDTH bits)
//   pe      in   synchronous parallel enable, loads p, highest priority
//   inh     in   clock inhibit, holds the counter while high
//   q       out  current down-count value
//   tc      out  terminal-count pulse, one cp0 cycle wide (flop output)
//   div_out out  toggles once per tc (flop output)
// ----------------------------------------------------------------------------
module ln_prescaler
    import ln_prescaler_pkg::*;
#(
    parameter int unsigned WIDTH = LN_DEFAULT_WIDTH
) (
    input  logic             cp0,
    input  logic             mr_n,
    input  logic [WIDTH-1:0] p,
    input  logic             pe,
    input  logic             inh,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             div_out
);

    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
    localparam logic [WIDTH-1:0] STALLED = WIDTH'(LN_RATIO_STALLED);

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_ratio;
    logic             r_tc;
    logic             r_div;
    logic             r_first;   // set by reset, cleared by the first load
    ln_act_e          w_act;

    // Priority: pe > inh > post-reset start > stall > wrap > decrement.
    // A stalled ratio always implies q = 0, so the stall test can use ratio.
    always_comb begin
        w_act = ACT_DEC;
        if (pe) begin
            w_act = ACT_LOAD;
        end else if (inh) begin
            w_act = ACT_HOLD;
        end else if (r_first) begin
            w_act = ACT_START;
        end else if (r_ratio == STALLED) begin
            w_act = ACT_STALL;
        end else if (r_q == ONE) begin
            w_act = ACT_WRAP;
        end
    end

    always_ff @(posedge cp0 or negedge mr_n) begin
        if (!mr_n) begin
            r_q     <= '0;
            r_ratio <= '0;
            r_tc    <= 1'b0;
            r_div   <= 1'b0;
            r_first <= 1'b1;
        end else begin
            r_tc <= 1'b0;
            case (w_act)
                ACT_LOAD, ACT_START: begin
                    r_q     <= p;
                    r_ratio <= p;
                    r_first <= 1'b0;
                end
                ACT_WRAP: begin
                    r_q     <= p;
                    r_ratio <= p;
                    r_tc    <= (p != '0);
                end
                ACT_DEC: begin
                    r_q <= r_q - ONE;
                end
                ACT_HOLD, ACT_STALL: begin
                end
                default: begin
                end
            endcase
            // div_out flips on the edge that closes a tc-high cycle; an
            // inhibited edge freezes it along with the rest of the state.
            if (r_tc && (w_act != ACT_HOLD)) begin
                r_div <= ~r_div;
            end
        end
    end

    assign q       = r_q;
    assign tc      = r_tc;
    assign div_out = r_div;

endmodule

// File: tb/tb_ln_prescaler.sv
module tb_ln_prescaler;

    localparam int W = 4;

    logic         cp0;
    logic         mr_n;
    logic [W-1:0] p;
    logic         pe;
    logic         inh;
    logic [W-1:0] q;
    logic         tc;
    logic         div_out;

    ln_prescaler #(.WIDTH(W)) dut (
        .cp0    (cp0),
        .mr_n   (mr_n),
        .p      (p),
        .pe     (pe),
        .inh    (inh),
        .q      (q),
        .tc     (tc),
        .div_out(div_out)
    );

    initial cp0 = 1'b0;
    always #5 cp0 = ~cp0;

    int errors = 0;
    int checks = 0;

    // Reference model: count value, period, pulse and divided clock,
    // stepped from the behavioural rules of the prescaler.
    int m_q;
    int m_ratio;
    int m_tc;
    int m_div;
    int m_need_start;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q = 0; m_ratio = 0; m_tc = 0; m_div = 0; m_need_start = 1;
    endtask

    task automatic model_edge();
        int pulse;
        int pv;
        pv = int'(p);
        pulse = 0;
        if (!mr_n) begin
            model_reset();
        end else begin
            // the divided clock reacts to a pulse that is ending, unless frozen
            if (m_tc == 1 && !(inh && !pe)) m_div = 1 - m_div;
            if (pe) begin
                m_q = pv; m_ratio = pv; m_need_start = 0;
            end else if (inh) begin
                // frozen
            end else if (m_need_start == 1) begin
                m_q = pv; m_ratio = pv; m_need_start = 0;
            end else if (m_q > 1) begin
                m_q = m_q - 1;
            end else if (m_q == 1) begin
                m_q = pv; m_ratio = pv;
                pulse = (pv != 0) ? 1 : 0;
            end
            m_tc = pulse;
        end
    endtask

    task automatic tick();
        @(posedge cp0);
        model_edge();
        #1;
        chk("q", 32'(q), 32'(m_q));
        chk("tc", 32'(tc), 32'(m_tc));
        chk("div_out", 32'(div_out), 32'(m_div));
    endtask

    // Assert reset away from a clock edge, check immediately, release on negedge.
    task automatic do_reset();
        mr_n = 1'b0;
        #1;
        model_reset();
        chk("rst_q", 32'(q), 32'd0);
        chk("rst_tc", 32'(tc), 32'd0);
        chk("rst_div", 32'(div_out), 32'd0);
        @(negedge cp0);
        mr_n = 1'b1;
    endtask

    initial begin
        int n_tc;
        int n_tog;
        int prev_div;
        int first_tc;
        int second_tc;
        int k;

        mr_n = 1'b0; p = 4'd3; pe = 1'b0; inh = 1'b0;
        model_reset();

        // Reset then p = 3 for 12 cycles
        do_reset();
        tick();
        chk("p3_first_q", 32'(q), 32'd3);
        chk("p3_first_tc", 32'(tc), 32'd0);
        n_tc = 0; n_tog = 0; prev_div = 0;
        for (int i = 0; i < 11; i++) begin
            tick();
            n_tc += int'(tc);
            if (int'(div_out) != prev_div) n_tog++;
            prev_div = int'(div_out);
        end
        chk("p3_tc_count", 32'(n_tc), 32'd3);
        chk("p3_div_toggles", 32'(n_tog), 32'd3);

        // p = 1: tc continuous after first reload
        p = 4'd1;
        do_reset();
        tick();
        chk("p1_first_tc", 32'(tc), 32'd0);
        prev_div = int'(div_out);
        tick();
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("p1_tc_high", 32'(tc), 32'd1);
            chk("p1_div_flip", 32'(div_out), 32'(1 - prev_div));
            prev_div = int'(div_out);
        end

        // p = 5, switch to 2 while q = 4
        p = 4'd5;
        do_reset();
        tick();
        tick();
        chk("pchg_q4", 32'(q), 32'd4);
        p = 4'd2;
        first_tc = -1; second_tc = -1;
        for (int i = 3; i <= 12; i++) begin
            tick();
            if (tc && first_tc < 0) first_tc = i;
            else if (tc && second_tc < 0) second_tc = i;
        end
        chk("pchg_first_tc", 32'(first_tc), 32'd6);
        chk("pchg_new_period", 32'(second_tc - first_tc), 32'd2);

        // p = 4, pe pulsed at q = 2
        p = 4'd4;
        do_reset();
        tick(); tick(); tick();
        chk("pe_q2", 32'(q), 32'd2);
        pe = 1'b1;
        tick();
        pe = 1'b0;
        chk("pe_q4", 32'(q), 32'd4);
        chk("pe_no_tc", 32'(tc), 32'd0);
        k = 0;
        while (k < 20 && !tc) begin
            tick();
            k++;
        end
        chk("pe_tc_latency", 32'(k), 32'd4);

        // inh for 3 cycles at q = 2
        do_reset();
        tick(); tick(); tick();
        chk("inh_q2", 32'(q), 32'd2);
        inh = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("inh_hold_q", 32'(q), 32'd2);
            chk("inh_tc_low", 32'(tc), 32'd0);
        end
        inh = 1'b0;
        k = 0;
        while (k < 20 && !tc) begin
            tick();
            k++;
        end
        chk("inh_resume", 32'(k), 32'd2);

        // p = 0: stall until pe with a non-zero p
        p = 4'd0;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("p0_q", 32'(q), 32'd0);
            chk("p0_tc", 32'(tc), 32'd0);
        end
        p = 4'd3; pe = 1'b1;
        tick();
        pe = 1'b0;
        chk("p0_pe_q", 32'(q), 32'd3);

        // reset mid-count, outputs clear without a clock edge
        tick(); tick();
        #3;
        mr_n = 1'b0;
        #1;
        model_reset();
        chk("async_q", 32'(q), 32'd0);
        chk("async_tc", 32'(tc), 32'd0);
        chk("async_div", 32'(div_out), 32'd0);
        @(negedge cp0);
        mr_n = 1'b1;

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                p = ($urandom_range(0, 15) == 0) ? 4'd0 : 4'(  $urandom_range(1, 15));
            end
            pe  = ($urandom_range(0, 11) == 0);
            inh = ($urandom_range(0, 6) == 0);
            if ($urandom_range(0, 99) == 0) do_reset();
            else tick();
        end
        pe = 1'b0; inh = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
